// File: rtl/btn_step_conditioner.sv
// -----------------------------------------------------------------------------
// btn_step_conditioner
//
// Turns two raw push-buttons into clean, single-cycle duty-step pulses for the
// PWM generator. Each button is synchronised into the clk_out domain and
// debounced on its own. A small FSM then emits one pulse per accepted press,
// can auto-repeat while a button is held, and locks out all pulses while both
// buttons are down.
//
// Ports
//   clk_out       in   divided system clock
//   rst_n         in   asynchronous reset, active-high (legacy polarity)
//   btn_up_raw    in   raw increase button, 1 = pressed
//   btn_down_raw  in   raw decrease button, 1 = pressed
//   repeat_en     in   1 = auto-repeat while held, sampled every cycle
//   inc_pulse     out  one-cycle increase step (registered)
//   dec_pulse     out  one-cycle decrease step (registered)
//   up_level      out  debounced level of the up button
//   down_level    out  debounced level of the down button
//   locked        out  1 while both-button lockout is active
// -----------------------------------------------------------------------------
module btn_step_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_RATE     = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk_out,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic repeat_en,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic up_level,
    output logic down_level,
    output logic locked
);

    localparam int unsigned NUM_BTN = 2;
    localparam int unsigned BTN_UP  = 0;
    localparam int unsigned BTN_DN  = 1;

    // Terminal counts; counters compare against these and never wrap.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD_UP = 3'd1,
        HOLD_DN = 3'd2,
        RPT_UP  = 3'd3,
        RPT_DN  = 3'd4,
        LOCK    = 3'd5
    } state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;

    assign raw = {btn_down_raw, btn_up_raw};

    // -------------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // -------------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   lvl_q;
        logic                   lvl_d;
        logic                   synced;

        assign synced = sync_q[SYNC_STAGES-1];

        // Shift chain; bit 0 is the metastability-exposed first stage.
        always_ff @(posedge clk_out or posedge rst_n) begin
            if (rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[b]};
            end
        end

        // Accept a new level only after it has differed for the full window;
        // any agreement with the current level restarts the count.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (synced != lvl_q) begin
                if (cnt_q == DEB_LAST) begin
                    lvl_d = synced;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_out or posedge rst_n) begin
            if (rst_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign level[b] = lvl_q;
    end

    // -------------------------------------------------------------------------
    // Step / repeat / lockout FSM
    // -------------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rtimer_q;
    logic [CNT_W-1:0] rtimer_d;
    logic             fire;
    logic             inc_q;
    logic             inc_d;
    logic             dec_q;
    logic             dec_d;
    logic             locked_q;
    logic             locked_d;
    logic             up_lvl;
    logic             dn_lvl;
    logic             own_lvl;
    logic             other_lvl;
    logic             is_up_side;

    assign up_lvl = level[BTN_UP];
    assign dn_lvl = level[BTN_DN];

    // State and registered outputs.
    always_ff @(posedge clk_out or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= IDLE;
            rtimer_q <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rtimer_q <= rtimer_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            locked_q <= locked_d;
        end
    end

    // Next state, repeat timer and the "emit a step" strobe.
    always_comb begin
        state_d    = state_q;
        rtimer_d   = rtimer_q;
        fire       = 1'b0;
        is_up_side = (state_q == HOLD_UP) || (state_q == RPT_UP);
        own_lvl    = is_up_side ? up_lvl : dn_lvl;
        other_lvl  = is_up_side ? dn_lvl : up_lvl;

        case (state_q)
            IDLE: begin
                rtimer_d = '0;
                if (up_lvl && dn_lvl) begin
                    state_d = LOCK;
                end else if (up_lvl) begin
                    state_d = HOLD_UP;
                    fire    = 1'b1;
                end else if (dn_lvl) begin
                    state_d = HOLD_DN;
                    fire    = 1'b1;
                end
            end

            HOLD_UP, HOLD_DN: begin
                if (!own_lvl) begin
                    state_d  = IDLE;
                    rtimer_d = '0;
                end else if (other_lvl) begin
                    state_d  = LOCK;
                    rtimer_d = '0;
                end else if (rtimer_q == DLY_LAST) begin
                    // Delay expired: wait here (timer parked) until repeat is allowed.
                    if (repeat_en) begin
                        fire     = 1'b1;
                        rtimer_d = '0;
                        state_d  = is_up_side ? RPT_UP : RPT_DN;
                    end
                end else begin
                    rtimer_d = rtimer_q + CNT_W'(1);
                end
            end

            RPT_UP, RPT_DN: begin
                if (!own_lvl) begin
                    state_d  = IDLE;
                    rtimer_d = '0;
                end else if (other_lvl) begin
                    state_d  = LOCK;
                    rtimer_d = '0;
                end else if (!repeat_en) begin
                    // Park in HOLD with the delay already served.
                    state_d  = is_up_side ? HOLD_UP : HOLD_DN;
                    rtimer_d = DLY_LAST;
                end else if (rtimer_q == RATE_LAST) begin
                    fire     = 1'b1;
                    rtimer_d = '0;
                end else begin
                    rtimer_d = rtimer_q + CNT_W'(1);
                end
            end

            LOCK: begin
                rtimer_d = '0;
                if (!up_lvl && !dn_lvl) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                rtimer_d = '0;
            end
        endcase
    end

    // Output decode; the direction of a step follows the state it lands in.
    always_comb begin
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        locked_d = (state_d == LOCK);
        if (fire) begin
            inc_d = (state_d == HOLD_UP) || (state_d == RPT_UP);
            dec_d = (state_d == HOLD_DN) || (state_d == RPT_DN);
        end
    end

    assign inc_pulse  = inc_q;
    assign dec_pulse  = dec_q;
    assign locked     = locked_q;
    assign up_level   = up_lvl;
    assign down_level = dn_lvl;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Bench for btn_step_conditioner: directed scenarios plus random button
// activity, all checked cycle by cycle against a behavioural model.
module tb_btn_step_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int DLY  = 64;
    localparam int RATE = 16;

    logic clk_out      = 1'b0;
    logic rst_n        = 1'b1;
    logic btn_up_raw   = 1'b0;
    logic btn_down_raw = 1'b0;
    logic repeat_en    = 1'b0;
    logic inc_pulse, dec_pulse, up_level, down_level, locked;

    int n_tests = 0;
    int n_fail  = 0;

    btn_step_conditioner dut (
        .clk_out      (clk_out),
        .rst_n        (rst_n),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .repeat_en    (repeat_en),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .up_level     (up_level),
        .down_level   (down_level),
        .locked       (locked)
    );

    always #5 clk_out = ~clk_out;

    // ---------------- behavioural model ----------------
    bit m_pipe [2][SYNC];
    int m_run  [2];
    bit m_lvl  [2];
    int m_mode  = 0;   // 0 idle, 1 up owns, 2 down owns, 3 lockout
    bit m_rep   = 0;   // in repeat phase
    int m_since = 0;   // edges since last step (capped at the current target)
    bit m_inc = 0, m_dec = 0, m_lock = 0;

    always @(posedge clk_out or posedge rst_n) begin : model_blk
        bit up_l, dn_l, own, other, smp;
        int target;
        if (rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < SYNC; s++) m_pipe[b][s] = 1'b0;
                m_run[b] = 0;
                m_lvl[b] = 1'b0;
            end
            m_mode = 0; m_rep = 0; m_since = 0;
            m_inc = 0; m_dec = 0; m_lock = 0;
        end else begin
            up_l = m_lvl[0];
            dn_l = m_lvl[1];
            m_inc = 0;
            m_dec = 0;
            case (m_mode)
                0: begin
                    if (up_l && dn_l) m_mode = 3;
                    else if (up_l) begin m_mode = 1; m_inc = 1; m_rep = 0; m_since = 0; end
                    else if (dn_l) begin m_mode = 2; m_dec = 1; m_rep = 0; m_since = 0; end
                end
                1, 2: begin
                    own   = (m_mode == 1) ? up_l : dn_l;
                    other = (m_mode == 1) ? dn_l : up_l;
                    if (!own) m_mode = 0;
                    else if (other) m_mode = 3;
                    else if (m_rep && !repeat_en) begin m_rep = 0; m_since = DLY; end
                    else begin
                        target = m_rep ? RATE : DLY;
                        if (m_since < target) m_since++;
                        if (m_since == target && (m_rep || repeat_en)) begin
                            m_since = 0;
                            m_rep   = 1;
                            if (m_mode == 1) m_inc = 1; else m_dec = 1;
                        end
                    end
                end
                default: if (!up_l && !dn_l) m_mode = 0;
            endcase
            m_lock = (m_mode == 3);
            for (int b = 0; b < 2; b++) begin
                if (m_pipe[b][SYNC-1] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin m_lvl[b] = m_pipe[b][SYNC-1]; m_run[b] = 0; end
                end else begin
                    m_run[b] = 0;
                end
            end
            for (int b = 0; b < 2; b++) begin
                for (int s = SYNC - 1; s > 0; s--) m_pipe[b][s] = m_pipe[b][s-1];
                smp = (b == 0) ? btn_up_raw : btn_down_raw;
                m_pipe[b][0] = smp;
            end
        end
    end

    logic [4:0] dut_v, mdl_v;
    assign dut_v = {inc_pulse, dec_pulse, up_level, down_level, locked};
    assign mdl_v = {m_inc, m_dec, m_lvl[0], m_lvl[1], m_lock};

    task automatic advance();
        @(posedge clk_out);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++;
            if (dut_v !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got %b want 00000", i, dut_v);
            end
        end
        rst_n = 1'b0;
        settle(2);
        n_tests++;
        if (dut_v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 00000", dut_v);
        end
    endtask

    task automatic test_single_press();
        int lvl_at = -1, first = -1, pulses = 0, decs = 0;
        repeat_en  = 1'b0;
        btn_up_raw = 1'b1;
        for (int t = 0; t < 70; t++) begin
            advance();
            if (t == 29) btn_up_raw = 1'b0;
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL single_press_model t=%0d got %b want %b", t, dut_v, mdl_v);
            end
            if (up_level === 1'b1 && lvl_at < 0) lvl_at = t;
            if (inc_pulse === 1'b1) begin pulses++; if (first < 0) first = t; end
            if (dec_pulse === 1'b1) decs++;
        end
        n_tests++;
        if (lvl_at != SYNC + DEB - 1) begin
            n_fail++;
            $display("FAIL single_press_level_edge got %0d want %0d", lvl_at, SYNC + DEB - 1);
        end
        n_tests++;
        if (first != SYNC + DEB) begin
            n_fail++;
            $display("FAIL single_press_pulse_edge got %0d want %0d", first, SYNC + DEB);
        end
        n_tests++;
        if (pulses != 1 || decs != 0) begin
            n_fail++;
            $display("FAIL single_press_count inc=%0d dec=%0d want inc=1 dec=0", pulses, decs);
        end
    endtask

    task automatic test_glitch(input int len, input int exp_pulses);
        int pulses = 0, lvl_hi = 0;
        btn_up_raw = 1'b1;
        for (int t = 0; t < len + 60; t++) begin
            advance();
            if (t == len - 1) btn_up_raw = 1'b0;
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL glitch%0d_model t=%0d got %b want %b", len, t, dut_v, mdl_v);
            end
            if (inc_pulse === 1'b1) pulses++;
            if (up_level === 1'b1) lvl_hi++;
        end
        n_tests++;
        if (pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL glitch%0d_pulses got %0d want %0d", len, pulses, exp_pulses);
        end
        n_tests++;
        if ((lvl_hi != 0) != (exp_pulses != 0)) begin
            n_fail++;
            $display("FAIL glitch%0d_level high_cycles=%0d want_high=%0d", len, lvl_hi, exp_pulses);
        end
    endtask

    task automatic test_auto_repeat();
        int p = -1, fall_t = -1, late = 0, incs = 0;
        bit seen_hi = 0;
        int offs[$];
        int exp_offs[$];
        exp_offs.push_back(0);
        for (int o = DLY; o <= 192; o += RATE) exp_offs.push_back(o);
        repeat_en    = 1'b1;
        btn_down_raw = 1'b1;
        for (int t = 0; t < 300; t++) begin
            advance();
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL repeat_model t=%0d got %b want %b", t, dut_v, mdl_v);
            end
            if (dec_pulse === 1'b1) begin
                if (p < 0) p = t;
                offs.push_back(t - p);
                if (fall_t >= 0 && t > fall_t) late++;
            end
            if (inc_pulse === 1'b1) incs++;
            if (down_level === 1'b1) seen_hi = 1;
            else if (seen_hi && fall_t < 0) fall_t = t;
            if (p >= 0 && t == p + 185) btn_down_raw = 1'b0;
        end
        btn_down_raw = 1'b0;
        n_tests++;
        if (p < 0) begin
            n_fail++;
            $display("FAIL repeat_first_pulse timeout: got none want one within 300 cycles");
        end
        n_tests++;
        if (offs.size() != exp_offs.size()) begin
            n_fail++;
            $display("FAIL repeat_count got %0d want %0d", offs.size(), exp_offs.size());
        end
        for (int i = 0; i < exp_offs.size(); i++) begin
            n_tests++;
            if (i >= offs.size() || offs[i] != exp_offs[i]) begin
                n_fail++;
                $display("FAIL repeat_offset[%0d] got %0d want %0d", i,
                         (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
            end
        end
        n_tests++;
        if (fall_t < 0 || late != 0 || incs != 0) begin
            n_fail++;
            $display("FAIL repeat_stop fall_t=%0d late=%0d inc=%0d want fall seen, 0, 0", fall_t, late, incs);
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_lock();
        int pulses = 0, unlocks = 0, first = -1;
        repeat_en  = 1'b0;
        btn_up_raw = 1'b1;
        settle(30);
        btn_down_raw = 1'b1;
        for (int t = 0; t < 40; t++) begin
            advance();
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL lock_enter_model t=%0d got %b want %b", t, dut_v, mdl_v);
            end
            if (inc_pulse === 1'b1 || dec_pulse === 1'b1) pulses++;
        end
        n_tests++;
        if (locked !== 1'b1 || pulses != 0) begin
            n_fail++;
            $display("FAIL lock_enter locked=%b pulses=%0d want 1,0", locked, pulses);
        end
        btn_up_raw = 1'b0;
        for (int t = 0; t < 40; t++) begin
            advance();
            if (locked !== 1'b1) unlocks++;
            if (inc_pulse === 1'b1 || dec_pulse === 1'b1) pulses++;
        end
        n_tests++;
        if (unlocks != 0 || pulses != 0 || up_level !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_hold_one unlocked=%0d pulses=%0d up=%b want 0,0,0", unlocks, pulses, up_level);
        end
        btn_down_raw = 1'b0;
        for (int t = 0; t < 40; t++) begin
            advance();
            if (inc_pulse === 1'b1 || dec_pulse === 1'b1) pulses++;
        end
        n_tests++;
        if (locked !== 1'b0 || pulses != 0 || down_level !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_release locked=%b pulses=%0d down=%b want 0,0,0", locked, pulses, down_level);
        end
        // A fresh press after unlock must step normally, showing we are idle.
        btn_up_raw = 1'b1;
        for (int t = 0; t < 30; t++) begin
            advance();
            if (inc_pulse === 1'b1 && first < 0) first = t;
        end
        btn_up_raw = 1'b0;
        n_tests++;
        if (first != SYNC + DEB) begin
            n_fail++;
            $display("FAIL lock_then_press pulse_edge got %0d want %0d", first, SYNC + DEB);
        end
        settle(40);
    endtask

    task automatic test_reset_mid_repeat();
        int first = -1;
        repeat_en  = 1'b1;
        btn_up_raw = 1'b1;
        settle(SYNC + DEB + DLY + 8);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (dut_v !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_async got %b want 00000", dut_v);
        end
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++;
            if (dut_v !== 5'b0) begin
                n_fail++;
                $display("FAIL midrst_held cyc %0d got %b want 00000", i, dut_v);
            end
        end
        rst_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            advance();
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL midrst_model k=%0d got %b want %b", k, dut_v, mdl_v);
            end
            if (inc_pulse === 1'b1 && first < 0) first = k;
        end
        n_tests++;
        if (first != SYNC + DEB + 1) begin
            n_fail++;
            $display("FAIL midrst_repulse edge got %0d want %0d", first, SYNC + DEB + 1);
        end
        btn_up_raw = 1'b0;
        repeat_en  = 1'b0;
        settle(40);
    endtask

    task automatic test_enable_drop();
        int pulses = 0, t1 = -1, t2 = -1;
        repeat_en  = 1'b1;
        btn_up_raw = 1'b1;
        settle(SYNC + DEB + DLY + 8);
        repeat_en = 1'b0;
        for (int t = 0; t < 100; t++) begin
            advance();
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL endrop_model t=%0d got %b want %b", t, dut_v, mdl_v);
            end
            if (inc_pulse === 1'b1 || dec_pulse === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL endrop_quiet pulses got %0d want 0", pulses);
        end
        repeat_en = 1'b1;
        for (int t = 1; t <= 3 * RATE; t++) begin
            advance();
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL enback_model t=%0d got %b want %b", t, dut_v, mdl_v);
            end
            if (inc_pulse === 1'b1) begin
                if (t1 < 0) t1 = t;
                else if (t2 < 0) t2 = t;
            end
        end
        n_tests++;
        if (t1 < 1 || t1 > RATE) begin
            n_fail++;
            $display("FAIL enback_first got %0d want 1..%0d", t1, RATE);
        end
        n_tests++;
        if (t2 - t1 != RATE) begin
            n_fail++;
            $display("FAIL enback_spacing got %0d want %0d", t2 - t1, RATE);
        end
        btn_up_raw = 1'b0;
        repeat_en  = 1'b0;
        settle(40);
    endtask

    task automatic test_random();
        int up_left = 0, dn_left = 0, both = 0, steps = 0;
        for (int i = 0; i < 4000; i++) begin
            if (up_left == 0) begin
                btn_up_raw = 1'($urandom_range(0, 1));
                up_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 250))
                                                      : int'($urandom_range(1, 30));
            end
            up_left--;
            if (dn_left == 0) begin
                btn_down_raw = 1'($urandom_range(0, 1));
                dn_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 250))
                                                      : int'($urandom_range(1, 30));
            end
            dn_left--;
            if ($urandom_range(0, 99) == 0) repeat_en = ~repeat_en;
            rst_n = ($urandom_range(0, 1499) == 0);
            advance();
            n_tests++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL random_model i=%0d got %b want %b", i, dut_v, mdl_v);
            end
            if (inc_pulse === 1'b1 && dec_pulse === 1'b1) both++;
            if (inc_pulse === 1'b1 || dec_pulse === 1'b1) steps++;
        end
        rst_n        = 1'b0;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        n_tests++;
        if (both != 0) begin
            n_fail++;
            $display("FAIL random_exclusive both_high=%0d want 0", both);
        end
        n_tests++;
        if (steps == 0) begin
            n_fail++;
            $display("FAIL random_activity steps=%0d want >0", steps);
        end
        settle(60);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch(15, 0);
        test_glitch(16, 1);
        test_auto_repeat();
        test_lock();
        test_reset_mid_repeat();
        test_enable_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded 2ms");
        $fatal(1);
    end

endmodule
